// File: rtl/axi_burst_master_p.sv
// Parametrised AXI4 burst master: one command at a time, IDLE->CHECK->addr->data->resp->FIN, done 2+ cycles after accept.
// Backpressure: data passes straight through valid/ready; stalls past TIMEOUT_CYC pulse timeout_err (resp/read-data phases abort).
module axi_burst_master_p #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int ID_W        = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [1:0]            cmd_burst,
    input  logic [DATA_W-1:0]     wd_data,
    input  logic [DATA_W/8-1:0]   wd_strb,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic [1:0]            rd_resp,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  timeout_err,
    output logic [ID_W-1:0]       m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_W-1:0]       m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_W-1:0]       m_axi_arid,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_W-1:0]       m_axi_rid,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, CHECK, WADDR, WDATA, WRESP, RADDR, RDATA, FIN
    } state_t;

    state_t              state, state_nxt;
    logic                wr_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [7:0]          len_r;
    logic [1:0]          burst_r;
    logic [ID_W-1:0]     tag;
    logic [7:0]          beat, beat_nxt;
    logic [1:0]          resp_acc, resp_nxt;
    logic [CNT_W-1:0]    stall;
    logic                hs, active, timeout_hit, illegal;
    logic [15:0]         span;
    logic [ADDR_W-1:0]   addr_aligned;

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign timeout_hit  = (stall == CNT_W'(TIMEOUT_CYC - 1));
    assign addr_aligned = addr_r & ~ADDR_W'(BYTES - 1);
    assign span         = 16'(addr_r[11:0]) + ((16'(len_r) + 16'd1) << SIZE);

    always_comb begin
        illegal = 1'b0;
        case (burst_r)
            2'b00:   illegal = (len_r > 8'd15);
            2'b01:   illegal = (span > 16'd4096);
            2'b10:   illegal = !(len_r inside {8'd1, 8'd3, 8'd7, 8'd15});
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        resp_nxt      = resp_acc;
        beat_nxt      = beat;
        hs            = 1'b0;
        active        = 1'b0;
        cmd_ready     = 1'b0;
        wd_ready      = 1'b0;
        rd_data       = '0;
        rd_resp       = 2'b00;
        rd_last       = 1'b0;
        rd_valid      = 1'b0;
        done          = 1'b0;
        done_resp     = 2'b00;
        timeout_err   = 1'b0;
        m_axi_awid    = '0;
        m_axi_awaddr  = '0;
        m_axi_awlen   = 8'd0;
        m_axi_awsize  = 3'd0;
        m_axi_awburst = 2'b00;
        m_axi_awvalid = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wlast   = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arid    = '0;
        m_axi_araddr  = '0;
        m_axi_arlen   = 8'd0;
        m_axi_arsize  = 3'd0;
        m_axi_arburst = 2'b00;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !m_axi_areset;
                if (cmd_valid && !m_axi_areset) begin
                    state_nxt = CHECK;
                    resp_nxt  = 2'b00;
                end
            end
            CHECK: begin
                if (illegal) begin
                    resp_nxt  = 2'b10;
                    state_nxt = FIN;
                end else begin
                    state_nxt = wr_r ? WADDR : RADDR;
                end
            end
            WADDR: begin
                active        = 1'b1;
                m_axi_awvalid = 1'b1;
                m_axi_awid    = tag;
                m_axi_awaddr  = addr_aligned;
                m_axi_awlen   = len_r;
                m_axi_awsize  = 3'(SIZE);
                m_axi_awburst = burst_r;
                hs            = m_axi_awready;
                if (hs) begin
                    beat_nxt  = 8'd0;
                    state_nxt = WDATA;
                end
            end
            WDATA: begin
                active       = 1'b1;
                m_axi_wvalid = wd_valid;
                m_axi_wdata  = wd_data;
                m_axi_wstrb  = wd_strb;
                m_axi_wlast  = (beat == len_r);
                wd_ready     = m_axi_wready;
                hs           = wd_valid && m_axi_wready;
                if (hs) begin
                    beat_nxt = beat + 8'd1;
                    if (beat == len_r)
                        state_nxt = WRESP;
                end
            end
            WRESP: begin
                active = 1'b1;
                if (timeout_hit) begin
                    resp_nxt  = 2'b11;
                    state_nxt = FIN;
                end else begin
                    m_axi_bready = 1'b1;
                    hs           = m_axi_bvalid;
                    if (hs) begin
                        resp_nxt  = worst(worst(resp_acc, m_axi_bresp),
                                          (m_axi_bid != tag) ? 2'b10 : 2'b00);
                        state_nxt = FIN;
                    end
                end
            end
            RADDR: begin
                active        = 1'b1;
                m_axi_arvalid = 1'b1;
                m_axi_arid    = tag;
                m_axi_araddr  = addr_aligned;
                m_axi_arlen   = len_r;
                m_axi_arsize  = 3'(SIZE);
                m_axi_arburst = burst_r;
                hs            = m_axi_arready;
                if (hs) begin
                    beat_nxt  = 8'd0;
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                active  = 1'b1;
                rd_data = m_axi_rdata;
                rd_resp = m_axi_rresp;
                rd_last = m_axi_rlast;
                if (timeout_hit) begin
                    resp_nxt  = 2'b11;
                    state_nxt = FIN;
                end else begin
                    rd_valid     = m_axi_rvalid;
                    m_axi_rready = rd_ready;
                    hs           = m_axi_rvalid && rd_ready;
                    if (hs) begin
                        // ID mismatch or rlast disagreeing with the beat count both flag SLVERR
                        resp_nxt = worst(worst(resp_acc, m_axi_rresp),
                                         ((m_axi_rid != tag) || (m_axi_rlast != (beat == len_r)))
                                         ? 2'b10 : 2'b00);
                        beat_nxt = beat + 8'd1;
                        if (m_axi_rlast)
                            state_nxt = FIN;
                    end
                end
            end
            FIN: begin
                done      = 1'b1;
                done_resp = resp_acc;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        timeout_err = active && timeout_hit && !hs;
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state    <= IDLE;
            wr_r     <= 1'b0;
            addr_r   <= '0;
            len_r    <= 8'd0;
            burst_r  <= 2'b00;
            tag      <= '0;
            beat     <= 8'd0;
            resp_acc <= 2'b00;
            stall    <= '0;
        end else begin
            state    <= state_nxt;
            beat     <= beat_nxt;
            resp_acc <= resp_nxt;
            if (state == IDLE && cmd_valid) begin
                wr_r    <= cmd_wr;
                addr_r  <= cmd_addr;
                len_r   <= cmd_len;
                burst_r <= cmd_burst;
            end
            if (state == FIN)
                tag <= tag + ID_W'(1);
            // In address/write-data phases the counter just restarts so valids stay asserted
            if (state_nxt != state || hs)
                stall <= '0;
            else if (active)
                stall <= timeout_hit ? '0 : stall + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_axi_burst_master_p.sv
// Directed bench for axi_burst_master_p (DATA_W=32, TIMEOUT_CYC=16); inputs change and outputs are sampled around the falling edge.
module tb_axi_burst_master_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_burst;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        wd_valid, wd_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_last, rd_valid, rd_ready;
    logic        done, timeout_err;
    logic [1:0]  done_resp;
    logic [2:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [3:0]  wstrb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_burst_master_p #(.DATA_W(32), .ADDR_W(32), .ID_W(3), .TIMEOUT_CYC(16)) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
        .wd_data(wd_data), .wd_strb(wd_strb), .wd_valid(wd_valid), .wd_ready(wd_ready),
        .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .done(done), .done_resp(done_resp), .timeout_err(timeout_err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready), .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents one command for a single cycle; returns on the falling edge with the DUT in CHECK.
    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst);
        tick();
        cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_burst = burst; cmd_valid = 1'b1;
        #1;
        tests++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL cmd_ready_idle got %b want 1", cmd_ready); fails++;
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_len = 0; cmd_burst = 0;
        wd_data = 0; wd_strb = 0; wd_valid = 0; rd_ready = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0; arready = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        tick(); tick(); #1;
        tests++;
        if ({cmd_ready, done, awvalid, awsize, arsize, wvalid, bready, rready, timeout_err} !== '0) begin
            $display("FAIL reset_outputs got rdy=%b done=%b awv=%b awsize=%0d want all 0",
                     cmd_ready, done, awvalid, awsize); fails++;
        end
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL reset_release_ready got %b want 1", cmd_ready); fails++;
        end
    endtask

    task automatic test_write_incr();
        issue_cmd(1'b1, 32'h100, 8'd3, 2'b01);
        tick(); #1;
        tests++;
        if ({awvalid, awaddr, awlen, awsize, awburst, awid} !== {1'b1, 32'h100, 8'd3, 3'd2, 2'b01, 3'd0}) begin
            $display("FAIL wr_aw_payload got v=%b a=%h len=%0d size=%0d burst=%b id=%0d",
                     awvalid, awaddr, awlen, awsize, awburst, awid); fails++;
        end
        tick(); tick();
        awready = 1'b1;
        #1;
        tests++;
        if (awvalid !== 1'b1) begin
            $display("FAIL wr_aw_hold got %b want 1", awvalid); fails++;
        end
        wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            awready = 1'b0;
            wd_valid = 1'b1; wd_data = 32'(i + 1); wd_strb = 4'hf;
            #1;
            tests++;
            if ({wvalid, wdata, wlast, wd_ready, wstrb} !== {1'b1, 32'(i + 1), (i == 3), 1'b1, 4'hf}) begin
                $display("FAIL wr_beat%0d got v=%b d=%h last=%b rdy=%b want d=%h last=%b",
                         i, wvalid, wdata, wlast, wd_ready, i + 1, (i == 3)); fails++;
            end
        end
        tick();
        wd_valid = 1'b0; bvalid = 1'b1; bid = 3'd0; bresp = 2'b00;
        #1;
        tests++;
        if ({bready, awvalid, wvalid} !== 3'b100) begin
            $display("FAIL wr_bready got bready=%b awv=%b wv=%b want 1 0 0", bready, awvalid, wvalid); fails++;
        end
        tick();
        bvalid = 1'b0;
        #1;
        tests++;
        if ({done, done_resp} !== {1'b1, 2'b00}) begin
            $display("FAIL wr_done got done=%b resp=%b want 1 00", done, done_resp); fails++;
        end
        tick(); #1;
        tests++;
        if ({done, cmd_ready} !== 2'b01) begin
            $display("FAIL wr_done_pulse got done=%b rdy=%b want 0 1", done, cmd_ready); fails++;
        end
    endtask

    task automatic test_read_wrap();
        int j;
        issue_cmd(1'b0, 32'h1C, 8'd7, 2'b10);
        tick(); #1;
        tests++;
        if ({arvalid, araddr, arlen, arsize, arburst, arid} !== {1'b1, 32'h1C, 8'd7, 3'd2, 2'b10, 3'd1}) begin
            $display("FAIL rd_ar_payload got v=%b a=%h len=%0d burst=%b id=%0d",
                     arvalid, araddr, arlen, arburst, arid); fails++;
        end
        arready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            arready = 1'b0;
            j = (c + 1) / 2;
            rd_ready = (c % 2 == 0);
            rvalid = 1'b1; rid = 3'd1; rdata = 32'hA0 + 32'(j); rlast = (j == 7);
            rresp = (j == 2) ? 2'b01 : (j == 5) ? 2'b10 : 2'b00;
            #1;
            tests++;
            if (rready !== rd_ready) begin
                $display("FAIL rd_rready_c%0d got %b want %b", c, rready, rd_ready); fails++;
            end
            if (rd_ready) begin
                tests++;
                if ({rd_valid, rd_data, rd_last, rd_resp} !== {1'b1, 32'hA0 + 32'(j), (j == 7), rresp}) begin
                    $display("FAIL rd_beat%0d got v=%b d=%h last=%b resp=%b", j, rd_valid, rd_data, rd_last, rd_resp);
                    fails++;
                end
            end
        end
        tick();
        rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0;
        #1;
        tests++;
        if ({done, done_resp} !== {1'b1, 2'b10}) begin
            $display("FAIL rd_wrap_done got done=%b resp=%b want 1 10", done, done_resp); fails++;
        end
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) issue_cmd(1'b0, 32'h0, 8'd5, 2'b10);
            else        issue_cmd(1'b1, 32'hFF8, 8'd3, 2'b01);
            #1;
            tests++;
            if ({awvalid, arvalid, done} !== 3'b000) begin
                $display("FAIL illegal%0d_check got awv=%b arv=%b done=%b want 000", k, awvalid, arvalid, done); fails++;
            end
            tick(); #1;
            tests++;
            if ({done, done_resp, awvalid, arvalid} !== {1'b1, 2'b10, 2'b00}) begin
                $display("FAIL illegal%0d_done got done=%b resp=%b awv=%b arv=%b", k, done, done_resp, awvalid, arvalid);
                fails++;
            end
        end
    endtask

    task automatic test_reset_mid();
        issue_cmd(1'b1, 32'h300, 8'd3, 2'b01);
        tick(); #1;
        tests++;
        if ({awvalid, awid} !== {1'b1, 3'd4}) begin
            $display("FAIL mid_awid got v=%b id=%0d want 1 4", awvalid, awid); fails++;
        end
        awready = 1'b1;
        wready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            awready = 1'b0; wd_valid = 1'b1; wd_data = 32'(i + 1);
        end
        tick();
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({cmd_ready, awvalid, wvalid, wd_ready, wlast, bready, arvalid, rready, done, timeout_err} !== '0) begin
            $display("FAIL mid_reset_outputs got rdy=%b wv=%b wrdy=%b done=%b want all 0",
                     cmd_ready, wvalid, wd_ready, done); fails++;
        end
        wd_valid = 1'b0;
        tick(); #1;
        tests++;
        if (done !== 1'b0) begin
            $display("FAIL mid_reset_no_done got %b want 0", done); fails++;
        end
        rst = 1'b0;
    endtask

    task automatic test_id_check();
        issue_cmd(1'b1, 32'hFF0, 8'd3, 2'b01);
        tick(); #1;
        tests++;
        if ({awvalid, awaddr, awid} !== {1'b1, 32'hFF0, 3'd0}) begin
            $display("FAIL id_aw_boundary got v=%b a=%h id=%0d want 1 ff0 0", awvalid, awaddr, awid); fails++;
        end
        awready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            awready = 1'b0; wd_valid = 1'b1; wd_data = 32'hD0 + 32'(i);
        end
        tick();
        wd_valid = 1'b0; bvalid = 1'b1; bid = 3'd3; bresp = 2'b00;
        tick();
        bvalid = 1'b0; bid = 3'd0;
        #1;
        tests++;
        if ({done, done_resp} !== {1'b1, 2'b10}) begin
            $display("FAIL id_bid_mismatch got done=%b resp=%b want 1 10", done, done_resp); fails++;
        end
    endtask

    task automatic test_rlast_early();
        issue_cmd(1'b0, 32'h400, 8'd3, 2'b01);
        tick(); #1;
        tests++;
        if ({arvalid, arid} !== {1'b1, 3'd1}) begin
            $display("FAIL early_arid got v=%b id=%0d want 1 1", arvalid, arid); fails++;
        end
        arready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            arready = 1'b0; rd_ready = 1'b1;
            rvalid = 1'b1; rid = 3'd1; rresp = 2'b00; rdata = 32'(i); rlast = (i == 1);
        end
        tick();
        rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0;
        #1;
        tests++;
        if ({done, done_resp} !== {1'b1, 2'b10}) begin
            $display("FAIL early_rlast got done=%b resp=%b want 1 10", done, done_resp); fails++;
        end
    endtask

    task automatic test_timeout_wresp();
        issue_cmd(1'b1, 32'h500, 8'd0, 2'b01);
        tick();
        awready = 1'b1;
        tick();
        awready = 1'b0; wd_valid = 1'b1;
        #1;
        tests++;
        if (wlast !== 1'b1) begin
            $display("FAIL to_wlast_single got %b want 1", wlast); fails++;
        end
        for (int c = 1; c <= 16; c++) begin
            tick();
            wd_valid = 1'b0;
            #1;
            tests++;
            if ({timeout_err, bready} !== {(c == 16), (c != 16)}) begin
                $display("FAIL to_wresp_c%0d got err=%b bready=%b", c, timeout_err, bready); fails++;
            end
        end
        tick(); #1;
        tests++;
        if ({done, done_resp, timeout_err} !== {1'b1, 2'b11, 1'b0}) begin
            $display("FAIL to_wresp_done got done=%b resp=%b err=%b want 1 11 0", done, done_resp, timeout_err);
            fails++;
        end
    endtask

    task automatic test_timeout_addr();
        issue_cmd(1'b1, 32'h600, 8'd0, 2'b01);
        for (int c = 1; c <= 40; c++) begin
            tick(); #1;
            tests++;
            if ({awvalid, timeout_err} !== {1'b1, (c == 16 || c == 32)}) begin
                $display("FAIL to_addr_c%0d got awv=%b err=%b", c, awvalid, timeout_err); fails++;
            end
        end
        tick();
        awready = 1'b1;
        tick();
        awready = 1'b0; wd_valid = 1'b1;
        tick();
        wd_valid = 1'b0; bvalid = 1'b1; bid = 3'd3; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        #1;
        tests++;
        if ({done, done_resp} !== {1'b1, 2'b00}) begin
            $display("FAIL to_addr_done got done=%b resp=%b want 1 00", done, done_resp); fails++;
        end
    endtask

    initial begin
        test_reset();
        test_write_incr();
        test_read_wrap();
        test_illegal();
        test_reset_mid();
        test_id_check();
        test_rlast_early();
        test_timeout_wresp();
        test_timeout_addr();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_burst_master_p.md
Name: axi_burst_master_p

Overview:
- Parametrised AXI4 burst master; successor to the fixed 32-bit master. Sits between a local command/stream client and an AXI4 interconnect port.
- Generalised data, address and ID widths. Write data comes from a valid/ready stream; read data leaves on a valid/ready stream.
- Adds legality checks (WRAP length, 4KB boundary), rotating transaction IDs, worst-case response aggregation and protocol-legal timeouts.

Parameters:
- DATA_W, 32, data width in bits; power of two, 32..256.
- ADDR_W, 32, address width.
- ID_W, 3, AXI ID width.
- TIMEOUT_CYC, 16, stall cycles before timeout_err pulses; must be ≥2.

Ports:
- m_axi_aclk  in  1  clock.
- m_axi_areset  in  1  reset (one clock, m_axi_aclk; reset m_axi_areset is asynchronous, active-high).
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_wr / cmd_addr / cmd_len / cmd_burst  in  1 / ADDR_W / 8 / 2  direction, byte address, beats-1, burst type (00 FIXED, 01 INCR, 10 WRAP).
- wd_data / wd_strb / wd_valid / wd_ready  in / in / in / out  DATA_W / DATA_W/8 / 1 / 1  write stream.
- rd_data / rd_resp / rd_last / rd_valid / rd_ready  out / out / out / out / in  DATA_W / 2 / 1 / 1 / 1  read stream.
- done / done_resp / timeout_err  out  1 / 2 / 1  completion pulse, aggregated response, stall flag.
- m_axi_awid / awaddr / awlen / awsize / awburst / awvalid  out  ID_W / ADDR_W / 8 / 3 / 2 / 1  write address channel.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata / wstrb / wlast / wvalid  out  DATA_W / DATA_W/8 / 1 / 1  write data channel.
- m_axi_wready  in  1  write data ready.
- m_axi_bid / bresp / bvalid  in  ID_W / 2 / 1  write response.
- m_axi_bready  out  1  write response ready.
- m_axi_arid / araddr / arlen / arsize / arburst / arvalid  out  ID_W / ADDR_W / 8 / 3 / 2 / 1  read address channel.
- m_axi_arready  in  1  read address ready.
- m_axi_rid / rdata / rresp / rlast / rvalid  in  ID_W / DATA_W / 2 / 1 / 1  read data.
- m_axi_rready  out  1  read data ready.

Behaviour:
- Reset:
  - While m_axi_areset is high, every output is 0, including cmd_ready.
  - State returns to IDLE and the ID tag resets to 0.
  - Reset mid-burst abandons the transfer immediately. No done pulse is generated.
- FSM states: IDLE, CHECK, WADDR, WDATA, WRESP, RADDR, RDATA, FIN.
- IDLE:
  - cmd_ready=1 (combinational, state==IDLE and not reset).
  - A cmd_valid&cmd_ready handshake registers the command and moves to CHECK.
- CHECK (1 cycle): the command is illegal if any of the following holds:
  - WRAP with cmd_len not in {1,3,7,15};
  - FIXED with cmd_len>15;
  - cmd_burst==11;
  - INCR where addr[11:0] + (cmd_len+1)*DATA_W/8 > 4096.
  - Illegal: go to FIN with done_resp=2'b10 and no bus activity.
  - Legal: go to WADDR if cmd_wr, else RADDR.
- Address phase:
  - aw/ar payload: addr with the low log2(DATA_W/8) bits forced to 0; size=log2(DATA_W/8); len=cmd_len; id=tag.
  - Valid is held until the ready handshake, then dropped in the following cycle. The next state is WDATA or RDATA.
- WDATA:
  - Combinational pass-through: m_axi_wvalid=wd_valid, wd_ready=m_axi_wready, and wdata/wstrb are copied.
  - An 8-bit beat counter increments on each handshake. m_axi_wlast=(beat==len).
  - The last-beat handshake moves to WRESP.
- WRESP: m_axi_bready=1. On bvalid, go to FIN.
- RDATA:
  - m_axi_rready=rd_ready, and rd_* is copied from m_axi_r*.
  - The beat counter increments on each handshake.
  - Handshake with rlast moves to FIN.
- done_resp aggregation: worst of all responses, with priority 11>10>01>00.
  - Forced to at least 10 on bid/rid≠tag.
  - Forced to at least 10 on rlast at beat≠len; FSM still ends on rlast.
  - Forced to at least 10 on a read beat==len without rlast; FSM keeps waiting.
- FIN (1 cycle): done=1 with done_resp. tag<=tag+1, wrapping at 2^ID_W. Return to IDLE.
- Timeout:
  - The stall counter counts cycles in WADDR/WDATA/WRESP/RADDR/RDATA without a handshake on the active channel. It clears on every handshake and on each state change.
  - At TIMEOUT_CYC: timeout_err pulses for 1 cycle.
  - In WADDR/WDATA/RADDR, valids stay asserted (AXI-legal) and the counter restarts.
  - In WRESP/RDATA: ready drops, then FIN with done_resp=2'b11.
- Simultaneous cmd_valid during a busy state: not accepted (cmd_ready=0).

Test Plan:
- Write INCR: DATA_W=32, addr 0x100, len 3, data 1,2,3,4, awready after 2 cycles, wready always -> awaddr 0x100, awlen 3, awsize 2, 4 beats with wlast on beat 4, bresp 00 -> done, done_resp 00, tag 0→1.
- Read WRAP: len 7, addr 0x1C, rd_ready toggling 1/0 -> arburst 10, 8 rd beats delivered in order, rd_last on 8th, done_resp = worst rresp injected (01 on beat 3, 10 on beat 6 → 10).
- Illegal: WRAP len 5, then INCR addr 0xFF8 len 3 (crosses 4KB) -> no aw/ar valid; done 2 cycles after accept, done_resp 10 both.
- Timeout: bvalid never asserted, TIMEOUT_CYC=16 -> timeout_err pulse after 16 WRESP cycles, bready drops, done_resp 11. Separately, awready held low 40 cycles -> awvalid stays 1 and timeout_err pulses at cycles 16 and 32.
- ID/last checks: bid≠tag -> done_resp 10. rlast on beat 2 of len 3 -> done after beat 2, done_resp 10.
- Reset mid-WDATA after 2 of 4 beats -> all outputs 0 asynchronously, no done; next command uses awid 0.
